psum_sram_arbiter: RTL and testbench
====================================

Name: psum_sram_arbiter

Overview:
- Arbitrates the single-port partial-sum SRAM between three requesters: OFIFO writeback, SFU (read-modify-write), and host/testbench readout.
- Replaces the ad-hoc CEN/WEN/address muxing in front of the psum SRAM with a priority arbiter that has a starvation guard, an SFU burst lock, and tagged read-data return.
- Sits between the corelet/controller outputs and the psum sram instance inside core.

Parameters:
- ADDR_W, 11, SRAM address width.
- DATA_W, 104, SRAM word width (psum_bw*col = 13*8).
- STARVE_LIM, 8, number of consecutive denied cycles after which a waiting SFU or host request is promoted.
- CNT_W, 4, width of each wait counter; must satisfy 2^CNT_W > STARVE_LIM.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ofifo_req  in  1  OFIFO write request.
- ofifo_addr  in  ADDR_W  OFIFO write address.
- ofifo_data  in  DATA_W  OFIFO write data.
- ofifo_gnt  out  1  OFIFO write accepted this cycle.
- sfu_req  in  1  SFU request.
- sfu_we  in  1  1 = SFU write, 0 = SFU read.
- sfu_lock  in  1  requests that the SFU keep the grant on its next request.
- sfu_addr  in  ADDR_W  SFU address.
- sfu_wdata  in  DATA_W  SFU write data.
- sfu_gnt  out  1  SFU access accepted this cycle.
- sfu_rvalid  out  1  rdata belongs to the SFU read granted last cycle.
- host_req  in  1  host read request.
- host_addr  in  ADDR_W  host read address.
- host_gnt  out  1  host read accepted this cycle.
- host_rvalid  out  1  rdata belongs to the host read granted last cycle.
- rdata  out  DATA_W  read data, passed through from sram_q.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_wen  out  1  SRAM write enable, active-low.
- sram_a  out  ADDR_W  SRAM address.
- sram_d  out  DATA_W  SRAM write data.
- sram_q  in  DATA_W  SRAM read data, valid one cycle after access.

Behaviour:
- Grants are combinational from the current requests and registered state. At most one grant is active per cycle.
- A granted access drives the SRAM pins in the same cycle, so the SRAM samples it at the next posedge.
- Requesters hold req, addr and data stable until they see gnt.
- Priority, highest first:
  1. starved host (host_wait == STARVE_LIM)
  2. locked SFU (lock_q && sfu_req)
  3. starved SFU
  4. OFIFO
  5. SFU
  6. host
- SRAM pins when a requester is granted:
  - sram_cen = 0.
  - sram_wen = 0 for an OFIFO grant, ~sfu_we for an SFU grant, 1 for a host grant.
  - sram_a and sram_d are muxed from the winner.
- SRAM pins with no grant: sram_cen = 1, sram_wen = 1, sram_a = 0, sram_d = 0.
- Wait counters (sfu_wait, host_wait):
  - Increment each cycle that req is high and gnt is low, saturating at STARVE_LIM.
  - Clear on grant, and clear whenever req is low.
- lock_q:
  - Set at the posedge following an SFU grant with sfu_lock = 1.
  - Cleared at any posedge where the SFU is not granted, or is granted with sfu_lock = 0.
  - A starved host overrides lock_q; lock_q is then cleared because the SFU was not granted.
- Read return:
  - A 2-bit tag register records whether an SFU read or a host read was granted.
  - The next cycle it raises the matching rvalid for one cycle, with rdata = sram_q.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalids, each with its own tag.
- Simultaneous events:
  - Requests that lose arbitration stay pending; nothing is dropped.
  - A requester dropping req in the same cycle it would be granted is simply not granted.
- Reset (asynchronous, applies at any time including mid-burst):
  - All grants 0, sram_cen = 1, sram_wen = 1, rvalids 0.
  - Counters 0, lock_q = 0, tag cleared.
  - A read in flight when reset asserts produces no rvalid.
- Latency: write takes effect 1 cycle after grant; read data arrives 1 cycle after grant. No bubble is inserted between grants, so full SRAM throughput of one access per cycle is sustained.

Decomposition:
- Shared package psum_arb_pkg holds:
  - the requester id encoding: NONE = 2'd0, OFIFO = 2'd1, SFU = 2'd2, HOST = 2'd3, used for the winner and the read tag;
  - the STARVE_LIM default.
- One natural sub-module, arb_wait_counter: saturating counter with inc/clr inputs and a starved output, instantiated twice (SFU, host).

Test Plan:
- Only ofifo_req, addr 0x005 / data D1 → same-cycle ofifo_gnt; sram_cen = 0, sram_wen = 0, sram_a = 0x005; a later host read of 0x005 gives host_rvalid with rdata = D1 one cycle after host_gnt.
- ofifo_req held continuously with host_req → host denied 8 cycles, host_gnt in cycle 9 (STARVE_LIM = 8), OFIFO granted the cycle after; host_wait returns to 0.
- SFU read 0x010 with sfu_lock = 1, then SFU write 0x010 next cycle while ofifo_req is high → SFU granted both cycles, OFIFO granted in the third cycle; sfu_rvalid is asserted in cycle 2.
- SFU locked burst while host is starved → host wins, lock_q drops, SFU is granted after host ahead of OFIFO only if sfu_wait has reached 8.
- Alternating SFU read and host read every cycle → rvalids alternate with the correct tags and no rvalid is lost.
- Assert reset one cycle after a host read grant → host_rvalid stays 0, all outputs at reset values immediately (asynchronous), and arbitration resumes normally after release.

Source files
------------

// File: rtl/psum_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_arb_pkg
//  Description : Shared definitions for the psum SRAM arbiter. Holds the
//                requester id encoding (used for both the arbitration winner
//                and the read-return tag) and the default starvation limit.
//  Revision    : 1.0  initial release
// ============================================================================
package psum_arb_pkg;

    // Requester identifiers; also the encoding of the 2-bit read tag.
    typedef enum logic [1:0] {
        ID_NONE  = 2'd0,
        ID_OFIFO = 2'd1,
        ID_SFU   = 2'd2,
        ID_HOST  = 2'd3
    } req_id_e;

    // Consecutive denied cycles before a waiting SFU/host request is promoted.
    localparam int STARVE_LIM_DEF = 8;

endpackage : psum_arb_pkg
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_wait_counter
//  Description : Saturating wait counter for one requester. Counts cycles a
//                request is pending but denied; flags starvation when the
//                count reaches STARVE_LIM.
//  Ports       : clk, reset (async, active-high)
//                inc_i     - request pending and not granted this cycle
//                clr_i     - request granted or request low this cycle
//                starved_o - count has reached STARVE_LIM
//  Revision    : 1.0  initial release
// ============================================================================
module arb_wait_counter #(
    parameter int CNT_W      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic starved_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear dominates; increment holds at the limit so the starved flag stays
    // asserted until the request is finally served or withdrawn.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == LIM);

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/psum_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psum_sram_arbiter
//  Description : Priority arbiter in front of the single-port psum SRAM.
//                Requesters: OFIFO writeback, SFU read/write, host readout.
//                Features a starvation guard for SFU/host, an SFU burst lock
//                and a tagged one-cycle read-data return.
//  Ports       : ofifo_* - OFIFO write request/grant
//                sfu_*   - SFU request, lock, grant and read-valid
//                host_*  - host read request, grant and read-valid
//                rdata   - read data (pass-through of sram_q)
//                sram_*  - SRAM pins (cen/wen active-low)
//  Revision    : 1.0  initial release
// ============================================================================
module psum_sram_arbiter
    import psum_arb_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 104,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ofifo_req,
    input  logic [ADDR_W-1:0] ofifo_addr,
    input  logic [DATA_W-1:0] ofifo_data,
    output logic              ofifo_gnt,
    input  logic              sfu_req,
    input  logic              sfu_we,
    input  logic              sfu_lock,
    input  logic [ADDR_W-1:0] sfu_addr,
    input  logic [DATA_W-1:0] sfu_wdata,
    output logic              sfu_gnt,
    output logic              sfu_rvalid,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    req_id_e winner;
    req_id_e tag_q;
    req_id_e tag_d;
    logic    lock_q;
    logic    lock_d;
    logic    sfu_starved;
    logic    host_starved;

    // ------------------------------------------------------------------
    // Starvation counters
    // ------------------------------------------------------------------
    arb_wait_counter #(
        .CNT_W      (CNT_W),
        .STARVE_LIM (STARVE_LIM)
    ) u_sfu_wait (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (sfu_req & ~sfu_gnt),
        .clr_i     (~sfu_req | sfu_gnt),
        .starved_o (sfu_starved)
    );

    arb_wait_counter #(
        .CNT_W      (CNT_W),
        .STARVE_LIM (STARVE_LIM)
    ) u_host_wait (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (host_req & ~host_gnt),
        .clr_i     (~host_req | host_gnt),
        .starved_o (host_starved)
    );

    // ------------------------------------------------------------------
    // Winner selection. Grants are combinational, so they are forced off
    // while reset is held to keep the SRAM idle during an async reset.
    // Starvation flags are qualified with req: a requester that withdraws
    // in the cycle it would have won is simply not granted.
    // ------------------------------------------------------------------
    always_comb begin
        winner = ID_NONE;
        if (reset) begin
            winner = ID_NONE;
        end else if (host_req && host_starved) begin
            winner = ID_HOST;
        end else if (lock_q && sfu_req) begin
            winner = ID_SFU;
        end else if (sfu_req && sfu_starved) begin
            winner = ID_SFU;
        end else if (ofifo_req) begin
            winner = ID_OFIFO;
        end else if (sfu_req) begin
            winner = ID_SFU;
        end else if (host_req) begin
            winner = ID_HOST;
        end
    end

    assign ofifo_gnt = (winner == ID_OFIFO);
    assign sfu_gnt   = (winner == ID_SFU);
    assign host_gnt  = (winner == ID_HOST);

    // ------------------------------------------------------------------
    // SRAM pin mux; idle pins are all-zero address/data with cen/wen high.
    // ------------------------------------------------------------------
    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        case (winner)
            ID_OFIFO: begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_a   = ofifo_addr;
                sram_d   = ofifo_data;
            end
            ID_SFU: begin
                sram_cen = 1'b0;
                sram_wen = ~sfu_we;
                sram_a   = sfu_addr;
                sram_d   = sfu_wdata;
            end
            ID_HOST: begin
                sram_cen = 1'b0;
                sram_a   = host_addr;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst lock and read-return tag
    // ------------------------------------------------------------------
    always_comb begin
        lock_d = sfu_gnt & sfu_lock;
        tag_d  = ID_NONE;
        if (sfu_gnt && !sfu_we) begin
            tag_d = ID_SFU;
        end else if (host_gnt) begin
            tag_d = ID_HOST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
            tag_q  <= ID_NONE;
        end else begin
            lock_q <= lock_d;
            tag_q  <= tag_d;
        end
    end

    assign sfu_rvalid  = (tag_q == ID_SFU);
    assign host_rvalid = (tag_q == ID_HOST);
    assign rdata       = sram_q;

endmodule : psum_sram_arbiter
`default_nettype wire

// File: tb/tb_psum_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_sram_arbiter
//  Description : Self-checking bench for psum_sram_arbiter. Contains an SRAM
//                model driving sram_q, a per-cycle reference model of the
//                arbitration rules, and directed scenarios with literal
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_sram_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 104;
    localparam int LIM = 8;

    localparam int W_NONE  = 0;
    localparam int W_OFIFO = 1;
    localparam int W_SFU   = 2;
    localparam int W_HOST  = 3;

    localparam logic [DW-1:0] D1 = 104'h11_2233_4455_6677_8899_aabb_ccdd;
    localparam logic [DW-1:0] D2 = 104'hde_adbe_ef01_2345_6789_abcd_ef00;
    localparam logic [DW-1:0] D3 = 104'h5a_a55a_a55a_a55a_a55a_a55a_a55a;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ofifo_req = 1'b0;
    logic [AW-1:0] ofifo_addr = '0;
    logic [DW-1:0] ofifo_data = '0;
    logic          ofifo_gnt;
    logic          sfu_req = 1'b0;
    logic          sfu_we = 1'b0;
    logic          sfu_lock = 1'b0;
    logic [AW-1:0] sfu_addr = '0;
    logic [DW-1:0] sfu_wdata = '0;
    logic          sfu_gnt;
    logic          sfu_rvalid;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] rdata;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    psum_sram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ofifo_req   (ofifo_req),
        .ofifo_addr  (ofifo_addr),
        .ofifo_data  (ofifo_data),
        .ofifo_gnt   (ofifo_gnt),
        .sfu_req     (sfu_req),
        .sfu_we      (sfu_we),
        .sfu_lock    (sfu_lock),
        .sfu_addr    (sfu_addr),
        .sfu_wdata   (sfu_wdata),
        .sfu_gnt     (sfu_gnt),
        .sfu_rvalid  (sfu_rvalid),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .rdata       (rdata),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    // Contents of a never-written word: a recognisable address pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8{2'b10, a}};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural single-port SRAM
    // ------------------------------------------------------------------
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    bit            mem_vld [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_wen === 1'b0) begin
                mem[sram_a]     <= sram_d;
                mem_vld[sram_a] <= 1'b1;
            end else begin
                sram_q <= mem_vld[sram_a] ? mem[sram_a] : pat(sram_a);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model state (committed on posedge) and its next values
    // (computed at negedge from the stable inputs).
    // ------------------------------------------------------------------
    int            m_hw = 0, m_sw = 0, m_tag = W_NONE;
    bit            m_lock = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    bit            exp_vld [0:(1<<AW)-1];

    int            n_hw = 0, n_sw = 0, n_tag = W_NONE;
    bit            n_lock = 1'b0, n_wr = 1'b0;
    logic [DW-1:0] n_rdata = '0, n_wd = '0;
    logic [AW-1:0] n_wa = '0;

    always @(negedge clk) begin : monitor
        int            w;
        logic          e_cen, e_wen;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        if (reset) begin
            chk1("rst_ofifo_gnt", ofifo_gnt, 1'b0);
            chk1("rst_sfu_gnt", sfu_gnt, 1'b0);
            chk1("rst_host_gnt", host_gnt, 1'b0);
            chk1("rst_cen", sram_cen, 1'b1);
            chk1("rst_wen", sram_wen, 1'b1);
            chk1("rst_sfu_rvalid", sfu_rvalid, 1'b0);
            chk1("rst_host_rvalid", host_rvalid, 1'b0);
            n_wr <= 1'b0;
        end else begin
            if (host_req && m_hw == LIM)      w = W_HOST;
            else if (m_lock && sfu_req)       w = W_SFU;
            else if (sfu_req && m_sw == LIM)  w = W_SFU;
            else if (ofifo_req)               w = W_OFIFO;
            else if (sfu_req)                 w = W_SFU;
            else if (host_req)                w = W_HOST;
            else                              w = W_NONE;

            chk1("m_ofifo_gnt", ofifo_gnt, w == W_OFIFO);
            chk1("m_sfu_gnt", sfu_gnt, w == W_SFU);
            chk1("m_host_gnt", host_gnt, w == W_HOST);

            e_cen = (w == W_NONE);
            e_wen = !((w == W_OFIFO) || (w == W_SFU && sfu_we));
            e_a   = (w == W_OFIFO) ? ofifo_addr : (w == W_SFU) ? sfu_addr :
                    (w == W_HOST) ? host_addr : '0;
            e_d   = (w == W_OFIFO) ? ofifo_data : (w == W_SFU) ? sfu_wdata : '0;
            chk1("m_cen", sram_cen, e_cen);
            chk1("m_wen", sram_wen, e_wen);
            chkw("m_addr", DW'(sram_a), DW'(e_a));
            chkw("m_wdata", sram_d, e_d);

            chk1("m_sfu_rvalid", sfu_rvalid, m_tag == W_SFU);
            chk1("m_host_rvalid", host_rvalid, m_tag == W_HOST);
            if (m_tag != W_NONE) chkw("m_rdata", rdata, m_rdata);

            n_hw   <= (host_req && w != W_HOST) ? ((m_hw + 1 > LIM) ? LIM : m_hw + 1) : 0;
            n_sw   <= (sfu_req && w != W_SFU) ? ((m_sw + 1 > LIM) ? LIM : m_sw + 1) : 0;
            n_lock <= (w == W_SFU) && sfu_lock;
            n_tag  <= (w == W_SFU && !sfu_we) ? W_SFU : (w == W_HOST) ? W_HOST : W_NONE;
            n_rdata <= exp_vld[e_a] ? exp_mem[e_a] : pat(e_a);
            n_wr   <= !e_wen;
            n_wa   <= e_a;
            n_wd   <= e_d;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hw   <= 0;
            m_sw   <= 0;
            m_lock <= 1'b0;
            m_tag  <= W_NONE;
        end else begin
            m_hw    <= n_hw;
            m_sw    <= n_sw;
            m_lock  <= n_lock;
            m_tag   <= n_tag;
            m_rdata <= n_rdata;
            if (n_wr) begin
                exp_mem[n_wa] <= n_wd;
                exp_vld[n_wa] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_cen", sram_cen, 1'b1);
        chk1("reset_host_rvalid", host_rvalid, 1'b0);
        step();
        reset = 1'b0;

        // OFIFO write then host read-back
        ofifo_req = 1'b1; ofifo_addr = 11'h005; ofifo_data = D1;
        @(negedge clk);
        chk1("t1_ofifo_gnt", ofifo_gnt, 1'b1);
        chk1("t1_cen", sram_cen, 1'b0);
        chk1("t1_wen", sram_wen, 1'b0);
        chkw("t1_addr", DW'(sram_a), DW'(11'h005));
        step();
        ofifo_req = 1'b0; host_req = 1'b1; host_addr = 11'h005;
        @(negedge clk);
        chk1("t1_host_gnt", host_gnt, 1'b1);
        step();
        host_req = 1'b0;
        @(negedge clk);
        chk1("t1_host_rvalid", host_rvalid, 1'b1);
        chkw("t1_rdata", rdata, D1);
        step();

        // Host starved by continuous OFIFO traffic
        ofifo_req = 1'b1; ofifo_addr = 11'h020; ofifo_data = D3;
        host_req = 1'b1; host_addr = 11'h005;
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            chk1("t2_host_denied", host_gnt, 1'b0);
            step();
        end
        @(negedge clk);
        chk1("t2_host_gnt_c9", host_gnt, 1'b1);
        chk1("t2_ofifo_held", ofifo_gnt, 1'b0);
        step();
        host_req = 1'b0;
        @(negedge clk);
        chk1("t2_ofifo_after", ofifo_gnt, 1'b1);
        chk1("t2_host_rvalid", host_rvalid, 1'b1);
        chkw("t2_rdata", rdata, D1);
        step();
        host_req = 1'b1;
        @(negedge clk);
        chk1("t2_wait_cleared", host_gnt, 1'b0);
        step();
        host_req = 1'b0; ofifo_req = 1'b0;
        step();

        // SFU locked read-modify-write ahead of OFIFO
        sfu_req = 1'b1; sfu_we = 1'b0; sfu_lock = 1'b1; sfu_addr = 11'h010;
        @(negedge clk);
        chk1("t3_sfu_rd_gnt", sfu_gnt, 1'b1);
        step();
        sfu_we = 1'b1; sfu_lock = 1'b0; sfu_wdata = D2;
        ofifo_req = 1'b1; ofifo_addr = 11'h030; ofifo_data = D3;
        @(negedge clk);
        chk1("t3_sfu_wr_gnt", sfu_gnt, 1'b1);
        chk1("t3_ofifo_wait", ofifo_gnt, 1'b0);
        chk1("t3_sfu_rvalid", sfu_rvalid, 1'b1);
        chkw("t3_rdata", rdata, pat(11'h010));
        step();
        sfu_req = 1'b0; sfu_we = 1'b0;
        @(negedge clk);
        chk1("t3_ofifo_gnt", ofifo_gnt, 1'b1);
        chk1("t3_no_wr_rvalid", sfu_rvalid, 1'b0);
        step();
        ofifo_req = 1'b0; host_req = 1'b1; host_addr = 11'h010;
        step();
        host_req = 1'b0;
        @(negedge clk);
        chkw("t3_readback", rdata, D2);
        step();

        // Locked SFU burst overridden by starved host
        sfu_req = 1'b1; sfu_we = 1'b0; sfu_lock = 1'b1; sfu_addr = 11'h040;
        host_req = 1'b1; host_addr = 11'h030;
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            chk1("t4_sfu_burst", sfu_gnt, 1'b1);
            step();
        end
        @(negedge clk);
        chk1("t4_host_override", host_gnt, 1'b1);
        chk1("t4_sfu_blocked", sfu_gnt, 1'b0);
        step();
        host_req = 1'b0;
        ofifo_req = 1'b1; ofifo_addr = 11'h050; ofifo_data = D1;
        @(negedge clk);
        chk1("t4_lock_dropped", ofifo_gnt, 1'b1);
        chkw("t4_host_rdata", rdata, D3);
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("t4_sfu_waiting", sfu_gnt, 1'b0);
            step();
        end
        @(negedge clk);
        chk1("t4_sfu_starved_gnt", sfu_gnt, 1'b1);
        step();
        sfu_req = 1'b0; sfu_lock = 1'b0;
        @(negedge clk);
        chk1("t4_sfu_rvalid", sfu_rvalid, 1'b1);
        step();
        ofifo_req = 1'b0;

        // Alternating SFU / host reads
        for (int i = 0; i < 6; i++) begin
            sfu_req  = (i % 2 == 0);
            sfu_addr = 11'h010;
            host_req = (i % 2 == 1);
            host_addr = 11'h005;
            @(negedge clk);
            if (i > 0) begin
                chk1("t5_sfu_rvalid", sfu_rvalid, (i % 2 == 1));
                chk1("t5_host_rvalid", host_rvalid, (i % 2 == 0));
            end
            step();
        end
        sfu_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        chk1("t5_last_host_rvalid", host_rvalid, 1'b1);
        chkw("t5_last_rdata", rdata, D1);
        step();

        // Asynchronous reset with a host read in flight
        host_req = 1'b1; host_addr = 11'h005;
        @(negedge clk);
        chk1("t6_host_gnt", host_gnt, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("t6_async_gnt", host_gnt, 1'b0);
        chk1("t6_async_cen", sram_cen, 1'b1);
        chk1("t6_async_wen", sram_wen, 1'b1);
        host_req = 1'b0;
        step();
        @(negedge clk);
        chk1("t6_no_rvalid", host_rvalid, 1'b0);
        step();
        reset = 1'b0;
        ofifo_req = 1'b1; ofifo_addr = 11'h060; ofifo_data = D2;
        @(negedge clk);
        chk1("t6_resume_gnt", ofifo_gnt, 1'b1);
        step();
        ofifo_req = 1'b0; host_req = 1'b1; host_addr = 11'h060;
        step();
        host_req = 1'b0;
        @(negedge clk);
        chk1("t6_resume_rvalid", host_rvalid, 1'b1);
        chkw("t6_resume_rdata", rdata, D2);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_psum_sram_arbiter
`default_nettype wire
